// File: rtl/bias_bank_sel_pkg.sv
// Shared layer package for the bias bank: lane width, packing and FSM encoding.
// Lane k of a packed vector occupies bits [k*BIAS_W +: BIAS_W].
package bias_bank_sel_pkg;

   localparam int BIAS_W_DFLT = 18;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/bias_bank_sel_regfile.sv
// Bias vector register file: one write port, one asynchronous read port.
// Storage is rounded up to a power of two so any index reads safely.
module bias_bank_regfile #(
   parameter int N_BANKS = 4,
   parameter int W       = 288,
   parameter int AW      = $clog2(N_BANKS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [2**AW];

   // bank storage, cleared on reset, written one word per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2**AW; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bias_bank_sel.sv
// Bias bank: streams bias vectors into banks, then presents one per cycle
// to the adder tree, selected externally or by auto-rotation.
module bias_bank_sel
   import bias_bank_sel_pkg::*;
#(
   parameter int N_ADDER_TREE = 16,
   parameter int BIAS_W       = BIAS_W_DFLT,
   parameter int N_BANKS      = 4,
   parameter int BANK_AW      = $clog2(N_BANKS)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             reload,
   input  logic                             load_valid,
   output logic                             load_ready,
   input  logic [N_ADDER_TREE*BIAS_W-1:0]   load_data,
   input  logic                             load_last,
   input  logic                             auto_mode,
   input  logic [BANK_AW-1:0]               sel_ext,
   input  logic                             advance,
   output logic [N_ADDER_TREE*BIAS_W-1:0]   bias_out,
   output logic                             bias_valid,
   output logic [BANK_AW-1:0]               bank_idx,
   output logic                             sel_err
);

   localparam int VW = N_ADDER_TREE * BIAS_W;
   localparam int CW = BANK_AW + 1;
   localparam logic [BANK_AW-1:0] LAST_BANK = BANK_AW'(N_BANKS - 1);

   logic [1:0]         r_state;
   logic [BANK_AW-1:0] r_wr_ptr;
   logic [BANK_AW-1:0] r_rot_ptr;
   logic [CW-1:0]      r_n_loaded;
   logic [VW-1:0]      r_bias_out;
   logic               r_bias_valid;
   logic [BANK_AW-1:0] r_bank_idx;
   logic               r_sel_err;

   logic [1:0]         w_state_nxt;
   logic [BANK_AW-1:0] w_wr_nxt;
   logic [BANK_AW-1:0] w_rot_nxt;
   logic [CW-1:0]      w_nl_nxt;
   logic               w_accept;
   logic               w_term;
   logic               w_adv;
   logic [BANK_AW-1:0] w_idx;
   logic               w_err;
   logic [VW-1:0]      w_rd;
   logic [VW-1:0]      w_data;

   assign w_accept = (r_state == ST_LOAD) & load_valid & ~reload;
   assign w_term   = w_accept & (load_last | (r_wr_ptr == LAST_BANK));
   assign w_adv    = (r_state == ST_RUN) & advance & auto_mode & ~reload;

   // next state and pointers; reload has priority over everything else
   always_comb begin
      w_state_nxt = r_state;
      w_wr_nxt    = r_wr_ptr;
      w_rot_nxt   = r_rot_ptr;
      w_nl_nxt    = r_n_loaded;
      unique case (1'b1)
         reload: begin
            w_state_nxt = ST_LOAD;
            w_wr_nxt    = '0;
         end
         w_accept: begin
            w_wr_nxt = r_wr_ptr + BANK_AW'(1);
            if (w_term) begin
               w_state_nxt = ST_RUN;
               w_nl_nxt    = CW'(r_wr_ptr) + CW'(1);
               w_rot_nxt   = '0;
            end
         end
         w_adv: begin
            if (CW'(r_rot_ptr) < r_n_loaded - CW'(1))
               w_rot_nxt = r_rot_ptr + BANK_AW'(1);
            else
               w_rot_nxt = '0;
         end
         default: ;
      endcase
   end

   // selection uses next-cycle pointers so the output lands one cycle later
   always_comb begin
      w_idx  = auto_mode ? w_rot_nxt : sel_ext;
      w_err  = ~auto_mode & (CW'(sel_ext) >= w_nl_nxt);
      w_data = (w_accept && (r_wr_ptr == w_idx)) ? load_data : w_rd;
   end

   bias_bank_regfile #(
      .N_BANKS (N_BANKS),
      .W       (VW),
      .AW      (BANK_AW)
   ) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_accept),
      .i_waddr (r_wr_ptr),
      .i_wdata (load_data),
      .i_raddr (w_idx),
      .o_rdata (w_rd)
   );

   // FSM and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_wr_ptr   <= '0;
         r_rot_ptr  <= '0;
         r_n_loaded <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wr_ptr   <= w_wr_nxt;
         r_rot_ptr  <= w_rot_nxt;
         r_n_loaded <= w_nl_nxt;
      end
   end

   // registered output stage; cleared whenever not running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bias_out   <= '0;
         r_bias_valid <= 1'b0;
         r_bank_idx   <= '0;
         r_sel_err    <= 1'b0;
      end else if (w_state_nxt == ST_RUN) begin
         r_bias_out   <= w_err ? '0 : w_data;
         r_bias_valid <= 1'b1;
         r_bank_idx   <= w_idx;
         r_sel_err    <= w_err;
      end else begin
         r_bias_out   <= '0;
         r_bias_valid <= 1'b0;
         r_bank_idx   <= '0;
         r_sel_err    <= 1'b0;
      end
   end

   assign load_ready = (r_state == ST_LOAD);
   assign bias_out   = r_bias_out;
   assign bias_valid = r_bias_valid;
   assign bank_idx   = r_bank_idx;
   assign sel_err    = r_sel_err;

endmodule

// File: tb/tb_bias_bank_sel.sv
// Scoreboard bench for bias_bank_sel: a queue-based reference model pushes
// the expected output per cycle, a monitor pops and compares.
module tb_bias_bank_sel;

   localparam int NL = 16;
   localparam int BW = 18;
   localparam int NB = 4;
   localparam int AW = 2;
   localparam int VW = NL * BW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          reload = 1'b0;
   logic          load_valid = 1'b0;
   logic          load_last = 1'b0;
   logic          auto_mode = 1'b1;
   logic          advance = 1'b0;
   logic [VW-1:0] load_data = '0;
   logic [AW-1:0] sel_ext = '0;
   logic          load_ready;
   logic          bias_valid;
   logic          sel_err;
   logic [VW-1:0] bias_out;
   logic [AW-1:0] bank_idx;

   always #5 clk = ~clk;

   bias_bank_sel #(
      .N_ADDER_TREE (NL),
      .BIAS_W       (BW),
      .N_BANKS      (NB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .reload     (reload),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_last  (load_last),
      .auto_mode  (auto_mode),
      .sel_ext    (sel_ext),
      .advance    (advance),
      .bias_out   (bias_out),
      .bias_valid (bias_valid),
      .bank_idx   (bank_idx),
      .sel_err    (sel_err)
   );

   typedef struct {
      logic          valid;
      logic          ready;
      logic          err;
      logic [AW-1:0] idx;
      logic [VW-1:0] data;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(string nm, logic [VW-1:0] act, logic [VW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
   endtask

   // reference model: phase plus the list of vectors in the current burst
   int phase;
   logic [VW-1:0] burst[$];
   int rot;
   int s;
   exp_t e_m;

   always @(posedge clk) begin
      if (!rst_n) begin
         phase = 0;
         burst.delete();
         rot = 0;
      end else if (reload) begin
         phase = 1;
         burst.delete();
      end else if (phase == 1 && load_valid) begin
         burst.push_back(load_data);
         if (load_last || burst.size() == NB) begin
            phase = 2;
            rot = 0;
         end
      end else if (phase == 2 && advance && auto_mode) begin
         rot = (rot + 1) % burst.size();
      end
      e_m.valid = (phase == 2);
      e_m.ready = (phase == 1);
      e_m.err = 1'b0;
      e_m.idx = '0;
      e_m.data = '0;
      if (phase == 2) begin
         s = auto_mode ? rot : int'(sel_ext);
         e_m.idx = AW'(s);
         if (s >= burst.size()) e_m.err = 1'b1;
         else e_m.data = burst[s];
      end
      q.push_back(e_m);
   end

   exp_t e_c;

   always @(negedge clk) begin
      if (q.size() > 0) begin
         e_c = q.pop_front();
         chk("bias_valid", VW'(bias_valid), VW'(e_c.valid));
         chk("load_ready", VW'(load_ready), VW'(e_c.ready));
         if (e_c.valid) begin
            chk("bias_out", bias_out, e_c.data);
            chk("sel_err", VW'(sel_err), VW'(e_c.err));
            chk("bank_idx", VW'(bank_idx), VW'(e_c.idx));
         end
      end
   end

   function automatic logic [VW-1:0] vec_of(logic [BW-1:0] v);
      logic [VW-1:0] r;
      for (int i = 0; i < NL; i++) r[i*BW +: BW] = v;
      return r;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] r;
      for (int i = 0; i < VW; i++) r[i] = 1'($urandom);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      reload = 1'b0;
      advance = 1'b0;
      load_valid = 1'b0;
      load_last = 1'b0;
   endtask

   task automatic rst_chk();
      chk("rst_bias_valid", VW'(bias_valid), '0);
      chk("rst_load_ready", VW'(load_ready), '0);
      chk("rst_sel_err", VW'(sel_err), '0);
      chk("rst_bank_idx", VW'(bank_idx), '0);
      chk("rst_bias_out", bias_out, '0);
   endtask

   task automatic load_seq(int n, int base);
      reload = 1'b1;
      step();
      for (int k = 1; k <= n; k++) begin
         load_valid = 1'b1;
         load_data = vec_of(BW'(k * base));
         load_last = (k == n);
         step();
      end
   endtask

   logic [VW-1:0] v;

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_chk();
      rst_n = 1'b1;
      step();
      step();

      auto_mode = 1'b1;
      load_seq(4, 1);
      step();
      repeat (4) begin
         advance = 1'b1;
         step();
         step();
      end
      advance = 1'b1;
      step();
      advance = 1'b1;
      step();
      step();

      load_seq(2, 16);
      repeat (3) begin
         advance = 1'b1;
         step();
      end
      auto_mode = 1'b0;
      sel_ext = 2'd3;
      advance = 1'b1;
      step();
      step();
      sel_ext = 2'd1;
      step();
      step();
      auto_mode = 1'b1;
      step();

      reload = 1'b1;
      step();
      v = rand_vec();
      v[0 +: BW] = 18'h3FFFF;
      v[15*BW +: BW] = 18'h20000;
      load_valid = 1'b1;
      load_data = v;
      load_last = 1'b1;
      step();
      chk("lane0", VW'(bias_out[0 +: BW]), VW'(18'h3FFFF));
      chk("lane15", VW'(bias_out[15*BW +: BW]), VW'(18'h20000));
      step();

      load_seq(4, 5);
      advance = 1'b1;
      step();
      reload = 1'b1;
      advance = 1'b1;
      step();
      step();

      load_seq(4, 7);
      load_seq(4, 3);
      step();
      reload = 1'b1;
      step();
      for (int k = 1; k <= 2; k++) begin
         load_valid = 1'b1;
         load_data = vec_of(BW'(k + 40));
         step();
      end
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      rst_chk();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      load_seq(4, 1);
      repeat (4) begin
         advance = 1'b1;
         step();
      end

      repeat (6) begin
         load_valid = 1'b1;
         load_data = rand_vec();
         load_last = 1'($urandom);
         advance = 1'($urandom);
         step();
      end

      repeat (400) begin
         reload = ($urandom_range(0, 19) == 0);
         load_valid = ($urandom_range(0, 3) != 0);
         load_data = rand_vec();
         load_last = ($urandom_range(0, 3) == 0);
         advance = 1'($urandom);
         if ($urandom_range(0, 9) == 0) auto_mode = ~auto_mode;
         sel_ext = AW'($urandom);
         step();
      end

      repeat (3) step();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
